// File: rtl/gmii_udp_demux.sv
// GMII receive-side UDP demultiplexer: parses Ethernet/IPv4/UDP headers, filters on IP/port,
// and splits payload into video-pixel and audio-word FIFO writes. Define UDP_LEN_CHECK_EN to drop short datagrams.
module gmii_udp_demux #(
    parameter logic [31:0] IPV4_DST = {8'd192, 8'd168, 8'd0, 8'd1},
    parameter logic [15:0] DST_PORT = 16'd12345,
    parameter int          ID_W     = 1,
    parameter int          BPP      = 2,
    parameter int          VID_PIX  = 640,
    parameter int          VID_W    = 16 + 8*BPP
) (
    input  logic             clk125,
    input  logic             sys_rst,
    input  logic [ID_W-1:0]  id,
    input  logic [7:0]       rxd,
    input  logic             rx_dv,
    input  logic             vid_full,
    output logic [VID_W-1:0] vid_data,
    output logic             vid_wr_en,
    input  logic             aud_full,
    output logic [23:0]      aud_data,
    output logic             aud_wr_en,
    output logic             packet_en,
    output logic             ovf_pulse,
    output logic [15:0]      pkt_cnt
);
    localparam int PRE_W = 8*BPP - 8;
    localparam int PC_W  = $clog2(VID_PIX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_VINFO, S_VID, S_ACNT, S_AUD, S_DROP, S_DONE
    } state_t;

    state_t           state_q;
    logic [10:0]      cnt_q, cnt_d;
    logic             skip_q;
    logic [15:0]      eth_type_q;
    logic [7:0]       ip_ver_q;
    logic [7:0]       proto_q;
    logic [31:0]      ip_dst_q;
    logic [15:0]      dst_port_q;
    logic [11:0]      y_q;
    logic [3:0]       xsel_q;
    logic [PRE_W-1:0] pix_q;
    logic [15:0]      aud_q;
    logic [1:0]       sub_q;
    logic [PC_W-1:0]  pix_cnt_q;
    logic [7:0]       words_q;
    logic [VID_W-1:0] vid_data_q;
    logic             vid_wr_en_q;
    logic [23:0]      aud_data_q;
    logic             aud_wr_en_q;
    logic             packet_en_q;
    logic             ovf_pulse_q;
    logic [15:0]      pkt_cnt_q;
    logic [7:0]       dst_octet;
    logic             filter_ok;
`ifdef UDP_LEN_CHECK_EN
    localparam logic [15:0] VID_REQ = 16'(11 + VID_PIX*BPP);
    logic [15:0]      udp_len_q;
    logic [15:0]      aud_req;
`endif

    always_comb begin
        cnt_d     = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
        dst_octet = IPV4_DST[7:0] + 8'(id);
        filter_ok = (eth_type_q == 16'h0800) && (ip_ver_q == 8'h45) && (proto_q == 8'h11) &&
                    (ip_dst_q == {IPV4_DST[31:8], dst_octet}) && (dst_port_q == DST_PORT);
`ifdef UDP_LEN_CHECK_EN
        aud_req   = 16'd10 + 16'(rxd) + {7'd0, rxd, 1'b0};
`endif
    end

    always_ff @(posedge clk125) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            skip_q      <= 1'b1;    // ignore the remainder of any frame already in flight
            eth_type_q  <= '0;
            ip_ver_q    <= '0;
            proto_q     <= '0;
            ip_dst_q    <= '0;
            dst_port_q  <= '0;
`ifdef UDP_LEN_CHECK_EN
            udp_len_q   <= '0;
`endif
            y_q         <= '0;
            xsel_q      <= '0;
            pix_q       <= '0;
            aud_q       <= '0;
            sub_q       <= '0;
            pix_cnt_q   <= '0;
            words_q     <= '0;
            vid_data_q  <= '0;
            vid_wr_en_q <= 1'b0;
            aud_data_q  <= '0;
            aud_wr_en_q <= 1'b0;
            packet_en_q <= 1'b0;
            ovf_pulse_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            vid_wr_en_q <= 1'b0;
            aud_wr_en_q <= 1'b0;
            ovf_pulse_q <= 1'b0;
            if (!rx_dv) begin
                state_q     <= S_IDLE;
                cnt_q       <= '0;
                skip_q      <= 1'b0;
                packet_en_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                case (state_q)
                    S_IDLE: if (!skip_q) state_q <= S_HDR;
                    S_HDR: begin
                        case (cnt_q)
                            11'h14, 11'h15:                 eth_type_q <= {eth_type_q[7:0], rxd};
                            11'h16:                         ip_ver_q   <= rxd;
                            11'h1F:                         proto_q    <= rxd;
                            11'h26, 11'h27, 11'h28, 11'h29: ip_dst_q   <= {ip_dst_q[23:0], rxd};
                            11'h2C, 11'h2D:                 dst_port_q <= {dst_port_q[7:0], rxd};
`ifdef UDP_LEN_CHECK_EN
                            11'h2E, 11'h2F:                 udp_len_q  <= {udp_len_q[7:0], rxd};
`endif
                            11'h32: begin
                                if (!filter_ok) begin
                                    state_q <= S_DROP;
                                end else if (rxd == 8'h00) begin
`ifdef UDP_LEN_CHECK_EN
                                    if (udp_len_q < VID_REQ) state_q <= S_DROP; else
`endif
                                    begin
                                        state_q   <= S_VINFO;
                                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                                    end
                                end else if (rxd == 8'h01) begin
                                    state_q   <= S_ACNT;
                                    pkt_cnt_q <= pkt_cnt_q + 16'd1;
                                end else begin
                                    state_q <= S_DROP;
                                end
                            end
                            default: ;
                        endcase
                    end
                    S_VINFO: begin
                        if (cnt_q == 11'h33) begin
                            y_q[7:0] <= rxd;
                        end else begin
                            y_q[11:8]   <= rxd[3:0];
                            xsel_q      <= rxd[7:4];
                            state_q     <= S_VID;
                            packet_en_q <= 1'b1;
                            sub_q       <= '0;
                            pix_cnt_q   <= '0;
                        end
                    end
                    S_VID: begin
                        if (sub_q == 2'(BPP - 1)) begin
                            sub_q <= '0;
                            if (vid_full) begin
                                ovf_pulse_q <= 1'b1;
                                state_q     <= S_DROP;
                                packet_en_q <= 1'b0;
                            end else begin
                                vid_wr_en_q <= 1'b1;
                                vid_data_q  <= {y_q, xsel_q, pix_q, rxd};
                                pix_cnt_q   <= pix_cnt_q + PC_W'(1);
                                if (pix_cnt_q == PC_W'(VID_PIX - 1)) begin
                                    state_q     <= S_DONE;
                                    packet_en_q <= 1'b0;
                                end
                            end
                        end else begin
                            pix_q <= PRE_W'({pix_q, rxd});
                            sub_q <= sub_q + 2'd1;
                        end
                    end
                    S_ACNT: begin
                        words_q <= rxd;
                        sub_q   <= '0;
`ifdef UDP_LEN_CHECK_EN
                        if (udp_len_q < aud_req) begin
                            state_q   <= S_DROP;
                            pkt_cnt_q <= pkt_cnt_q - 16'd1;   // undo the count taken at the type byte
                        end else
`endif
                        if (rxd == 8'h00) state_q <= S_DONE;
                        else              state_q <= S_AUD;
                    end
                    S_AUD: begin
                        if (sub_q == 2'd2) begin
                            sub_q <= '0;
                            if (aud_full) begin
                                ovf_pulse_q <= 1'b1;
                                state_q     <= S_DROP;
                            end else begin
                                aud_wr_en_q <= 1'b1;
                                aud_data_q  <= {aud_q, rxd};
                                words_q     <= words_q - 8'd1;
                                if (words_q == 8'd1) state_q <= S_DONE;
                            end
                        end else begin
                            aud_q <= {aud_q[7:0], rxd};
                            sub_q <= sub_q + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign vid_data  = vid_data_q;
    assign vid_wr_en = vid_wr_en_q;
    assign aud_data  = aud_data_q;
    assign aud_wr_en = aud_wr_en_q;
    assign packet_en = packet_en_q;
    assign ovf_pulse = ovf_pulse_q;
    assign pkt_cnt   = pkt_cnt_q;
endmodule

// File: tb/tb_gmii_udp_demux.sv
// Scoreboard bench for gmii_udp_demux: a frame-level reference model fills expected queues,
// and a negedge monitor pops and compares on every FIFO write strobe.
module tb_gmii_udp_demux;
    localparam int BPP     = 2;
    localparam int VID_PIX = 640;
    localparam int VID_W   = 16 + 8*BPP;

    logic             clk125 = 1'b0;
    logic             sys_rst;
    logic [0:0]       id;
    logic [7:0]       rxd;
    logic             rx_dv;
    logic             vid_full;
    logic [VID_W-1:0] vid_data;
    logic             vid_wr_en;
    logic             aud_full;
    logic [23:0]      aud_data;
    logic             aud_wr_en;
    logic             packet_en;
    logic             ovf_pulse;
    logic [15:0]      pkt_cnt;

    always #4 clk125 = ~clk125;

    gmii_udp_demux dut (
        .clk125(clk125), .sys_rst(sys_rst), .id(id), .rxd(rxd), .rx_dv(rx_dv),
        .vid_full(vid_full), .vid_data(vid_data), .vid_wr_en(vid_wr_en),
        .aud_full(aud_full), .aud_data(aud_data), .aud_wr_en(aud_wr_en),
        .packet_en(packet_en), .ovf_pulse(ovf_pulse), .pkt_cnt(pkt_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [VID_W-1:0] exp_vid[$];
    logic [23:0]      exp_aud[$];
    logic [7:0]       fb[$];
    bit               fvf[$];
    bit               faf[$];
    int exp_pkt  = 0;
    int exp_ovf  = 0;
    int ovf_seen = 0;
    int cur_id   = 0;
    int cidx[7]  = '{20, 21, 22, 31, 41, 44, 45};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: every write strobe must match the oldest expected word.
    always @(negedge clk125) begin
        if (vid_wr_en === 1'b1) begin
            if (exp_vid.size() > 0) check("vid_data", vid_data, exp_vid.pop_front());
            else                    check("vid_extra_write", vid_wr_en, 0);
        end
        if (aud_wr_en === 1'b1) begin
            if (exp_aud.size() > 0) check("aud_data", aud_data, exp_aud.pop_front());
            else                    check("aud_extra_write", aud_wr_en, 0);
        end
        if (ovf_pulse === 1'b1) begin
            ovf_seen++;
            check("ovf_exclusive", {31'd0, vid_wr_en | aud_wr_en}, 0);
        end
    end

    function automatic logic [7:0] rb();
        return 8'($urandom);
    endfunction

    task automatic add(input logic [7:0] b);
        fb.push_back(b);
        fvf.push_back(1'b0);
        faf.push_back(1'b0);
    endtask

    task automatic build_hdr(input logic [7:0] octet, input logic [7:0] typ, input int ulen);
        fb.delete(); fvf.delete(); faf.delete();
        repeat (7) add(8'h55);
        add(8'hD5);
        repeat (12) add(rb());
        add(8'h08); add(8'h00); add(8'h45); add(8'h00);
        add(8'((ulen + 20) >> 8)); add(8'(ulen + 20));
        add(rb()); add(rb()); add(8'h40); add(8'h00); add(8'd64); add(8'h11);
        repeat (6) add(rb());
        add(8'd192); add(8'd168); add(8'd0); add(octet);
        add(rb()); add(rb()); add(8'h30); add(8'h39);
        add(8'(ulen >> 8)); add(8'(ulen));
        add(rb()); add(rb());
        add(typ);
    endtask

    task automatic add_video(input logic [11:0] y, input logic [3:0] xs, input bit rnd);
        add(y[7:0]);
        add({xs, y[11:8]});
        for (int p = 0; p < VID_PIX; p++) begin
            if (rnd) begin add(rb()); add(rb()); end
            else     begin add(8'hAB); add(8'hCD); end
        end
        repeat (4) add(rb());
    endtask

    // Reference model: walk the frame as the receiver should see it and list the writes it owes.
    task automatic model_frame(input int rst_at, input int probe, output bit pe);
        int len, stop, last, n;
        logic [11:0] y;
        logic [3:0]  xs;
        logic [7:0]  want_oct, b;
        pe = 1'b0;
        len = (rst_at >= 0 && rst_at < fb.size()) ? rst_at : fb.size();
        want_oct = 8'(1 + cur_id);
        if (len > 50 && {fb[20], fb[21]} == 16'h0800 && fb[22] == 8'h45 && fb[31] == 8'h11 &&
            fb[38] == 8'd192 && fb[39] == 8'd168 && fb[40] == 8'd0 && fb[41] == want_oct &&
            {fb[44], fb[45]} == 16'd12345) begin
            if (fb[50] == 8'h00) begin
                exp_pkt++;
                stop = len - 1;
                if (len > 52) begin
                    b  = fb[52];
                    y  = {b[3:0], fb[51]};
                    xs = b[7:4];
                    for (int p = 0; p < VID_PIX; p++) begin
                        last = 54 + 2*p;
                        if (last >= len) break;
                        if (fvf[last]) begin exp_ovf++; stop = last; break; end
                        exp_vid.push_back({y, xs, fb[last-1], fb[last]});
                        if (p == VID_PIX - 1) stop = last;
                    end
                end
                pe = (probe >= 53) && (probe <= stop);
            end else if (fb[50] == 8'h01) begin
                exp_pkt++;
                if (len > 51) begin
                    n = int'(fb[51]);
                    for (int w = 0; w < n; w++) begin
                        last = 54 + 3*w;
                        if (last >= len) break;
                        if (faf[last]) begin exp_ovf++; break; end
                        exp_aud.push_back({fb[last-2], fb[last-1], fb[last]});
                    end
                end
            end
        end
        if (rst_at >= 0 && rst_at < fb.size()) exp_pkt = 0;
    endtask

    task automatic send_frame(input int rst_at, input int probe);
        bit pe_exp;
        model_frame(rst_at, probe, pe_exp);
        for (int i = 0; i < fb.size(); i++) begin
            @(posedge clk125); #1;
            rx_dv    = 1'b1;
            rxd      = fb[i];
            vid_full = fvf[i];
            aud_full = faf[i];
            sys_rst  = (i == rst_at);
            if (i == probe && (rst_at < 0 || i < rst_at)) begin
                @(negedge clk125);
                check("packet_en_mid", {31'd0, packet_en}, {31'd0, pe_exp});
            end
            if (rst_at >= 0 && i == rst_at + 1) begin
                @(negedge clk125);
                check("rst_flags", {28'd0, vid_wr_en, aud_wr_en, packet_en, ovf_pulse}, 0);
                check("rst_pkt_cnt", {16'd0, pkt_cnt}, 0);
                check("rst_data", vid_data | {8'd0, aud_data}, 0);
            end
        end
        @(posedge clk125); #1;
        rx_dv = 1'b0; vid_full = 1'b0; aud_full = 1'b0; sys_rst = 1'b0;
        repeat (12) @(posedge clk125);
        @(negedge clk125);
        check("vid_pending", exp_vid.size(), 0);
        check("aud_pending", exp_aud.size(), 0);
        check("pkt_cnt", {16'd0, pkt_cnt}, 32'(exp_pkt & 16'hFFFF));
        check("ovf_count", ovf_seen, exp_ovf);
        check("packet_en_idle", {31'd0, packet_en}, 0);
        exp_vid.delete();
        exp_aud.delete();
    endtask

    initial begin
        int kind, n, newlen, r;
        logic [7:0] typ, octet;
        sys_rst = 1'b1; rx_dv = 1'b0; rxd = 8'h00; vid_full = 1'b0; aud_full = 1'b0; id = 1'b0;
        repeat (3) @(posedge clk125);
        @(negedge clk125);
        check("reset_flags", {28'd0, vid_wr_en, aud_wr_en, packet_en, ovf_pulse}, 0);
        check("reset_pkt_cnt", {16'd0, pkt_cnt}, 0);
        check("reset_data", vid_data | {8'd0, aud_data}, 0);
        @(posedge clk125); #1;
        sys_rst = 1'b0;
        repeat (4) @(posedge clk125);

        // Video, id=0, y=0x123, xsel=5, constant pixel.
        cur_id = 0; id = 1'b0;
        build_hdr(8'd1, 8'h00, 11 + 2*VID_PIX);
        add_video(12'h123, 4'h5, 1'b0);
        send_frame(-1, 'h100);

        // id=1: frame to .1 rejected, then .2 accepted.
        cur_id = 1; id = 1'b1;
        build_hdr(8'd1, 8'h00, 11 + 2*VID_PIX);
        add_video(12'h0A5, 4'h2, 1'b1);
        send_frame(-1, 'h80);
        build_hdr(8'd2, 8'h00, 11 + 2*VID_PIX);
        add_video(12'h0A5, 4'h2, 1'b1);
        send_frame(-1, 'h80);

        // Audio with three words and trailing bytes.
        cur_id = 0; id = 1'b0;
        build_hdr(8'd1, 8'h01, 19);
        add(8'd3);
        for (int k = 1; k <= 9; k++) add(8'(k));
        repeat (6) add(rb());
        send_frame(-1, -1);

        // Video FIFO full on pixel 10's last byte.
        build_hdr(8'd1, 8'h00, 11 + 2*VID_PIX);
        add_video(12'h321, 4'h9, 1'b1);
        fvf[54 + 2*9] = 1'b1;
        send_frame(-1, 200);

        // rx_dv falls mid-pixel, then a normal frame.
        build_hdr(8'd1, 8'h00, 11 + 2*VID_PIX);
        add(8'h10); add(8'h20); add(8'hAB);
        send_frame(-1, -1);
        build_hdr(8'd1, 8'h00, 11 + 2*VID_PIX);
        add_video(12'h456, 4'h1, 1'b1);
        send_frame(-1, 60);

        // Reset at pixel 100, then a normal frame.
        build_hdr(8'd1, 8'h00, 11 + 2*VID_PIX);
        add_video(12'h777, 4'h3, 1'b1);
        send_frame(53 + 2*100, 150);
        build_hdr(8'd1, 8'h00, 11 + 2*VID_PIX);
        add_video(12'h888, 4'h4, 1'b1);
        send_frame(-1, 500);

        // Randomized frames.
        for (int f = 0; f < 14; f++) begin
            kind   = $urandom_range(0, 9);
            typ    = (kind < 3) ? 8'h00 : (kind < 8) ? 8'h01 : 8'($urandom_range(2, 255));
            cur_id = $urandom_range(0, 1);
            id     = cur_id[0:0];
            octet  = ($urandom_range(0, 7) == 0) ? rb() : 8'(1 + cur_id);
            build_hdr(octet, typ, 100);
            if (typ == 8'h00) begin
                add_video(12'($urandom), 4'($urandom), 1'b1);
            end else if (typ == 8'h01) begin
                n = $urandom_range(0, 12);
                add(8'(n));
                repeat (3*n + 4) add(rb());
            end else begin
                repeat (20) add(rb());
            end
            if ($urandom_range(0, 4) == 0) begin
                r = cidx[$urandom_range(0, 6)];
                fb[r] = fb[r] ^ 8'h01;
            end
            repeat (2) begin
                if ($urandom_range(0, 1) == 1) fvf[$urandom_range(53, fb.size() - 1)] = 1'b1;
                if ($urandom_range(0, 1) == 1) faf[$urandom_range(53, fb.size() - 1)] = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) begin
                newlen = $urandom_range(40, fb.size());
                while (fb.size() > newlen) begin
                    void'(fb.pop_back()); void'(fvf.pop_back()); void'(faf.pop_back());
                end
            end
            send_frame(-1, $urandom_range(53, 300));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
